rc4_prga_checker: RTL and testbench
===================================

Name: rc4_prga_checker

Overview:
Parametrised RC4 keystream generator and decrypter (PRGA stage). It runs after the key-schedule/shuffle stage has left a permuted 256-byte S array in scratch RAM. Each ciphertext byte is read from message ROM, XORed with the next keystream byte, and written to result RAM. Each plaintext byte can also be checked against a legal character range, with early abort on the first illegal byte, so a key-search controller can reject wrong keys quickly.

Parameters:
MESSAGE_LEN, 32, message length in bytes, 1..256
MSG_ADDR_WIDTH, 5, message/result address width; must satisfy 2**MSG_ADDR_WIDTH >= MESSAGE_LEN
CHECK_EN, 1, 1 = abort on illegal plaintext byte; 0 = decrypt full message unconditionally
CHAR_LO, 8'd97, lowest legal plaintext byte (inclusive)
CHAR_HI, 8'd122, highest legal plaintext byte (inclusive)
ALLOW_SPACE, 1, 1 = 8'd32 is also legal

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin run; sampled only in IDLE
finish  out  1  run complete; held until start is low
pass  out  1  valid with finish; 1 = all MESSAGE_LEN bytes legal (or CHECK_EN=0)
bytes_done  out  MSG_ADDR_WIDTH+1  count of result bytes written this run
s_addr  out  8  scratch S RAM address
s_data  out  8  scratch write data
s_wren  out  1  scratch write enable
s_q  in  8  scratch read data
msg_addr  out  MSG_ADDR_WIDTH  ciphertext ROM address
msg_q  in  8  ciphertext ROM data
result_addr  out  MSG_ADDR_WIDTH  plaintext RAM address
result_data  out  8  plaintext write data
result_wren  out  1  plaintext write enable

Behaviour:
- All memories are synchronous with a registered address: the address is presented in cycle N, and q is valid in cycle N+1.
- Memory outputs are decoded from registered state, so they are valid during the state in which they are listed below.
- Reset (asynchronous): state=IDLE; i, j, k, si, sj, f, m cleared. All outputs are 0, including finish, pass, bytes_done and every wren.
- Reset mid-run: the block aborts immediately and drives no further writes. Scratch and result RAM contents are then undefined.
- IDLE: all wren=0. If start=1, go to RD_I and set i<=1, j<=0, k<=0, bytes_done<=0.
- Per-byte sequence, 9 cycles per byte, all index arithmetic mod 256 (8-bit wrap, carry dropped):
  RD_I: s_addr=i
  LD_I: si<=s_q; j<=j+s_q
  RD_J: s_addr=j
  LD_J: sj<=s_q
  WR_I: s_addr=i, s_data=sj, s_wren=1
  WR_J: s_addr=j, s_data=si, s_wren=1
  RD_F: s_addr=si+sj, msg_addr=k
  LD_F: f<=s_q; m<=msg_q
  WR_R: result_addr=k, result_data=f^m, result_wren=1; bytes_done<=k+1
- After WR_R:
  - If CHECK_EN=1 and the byte is illegal: go to DONE with pass<=0.
  - Else if k==MESSAGE_LEN-1: go to DONE with pass<=1.
  - Else: k<=k+1, i<=i+1, return to RD_I.
- Legal byte: CHAR_LO <= b <= CHAR_HI, or (ALLOW_SPACE=1 and b==32).
- i==j: the WR_I then WR_J order leaves s[i] unchanged, which is correct RC4. No special case is needed.
- i wraps 255->0 when MESSAGE_LEN >= 256 and must continue correctly.
- Illegal byte: it is still written to result RAM before the abort. bytes_done includes it.
- DONE: finish=1, pass held. Return to IDLE only when start=0. A start held high does not retrigger.
- start asserted outside IDLE is ignored.
- Latency: start sampled high in IDLE at edge 0; finish=1 from cycle 9*n+1, where n = bytes processed (MESSAGE_LEN on pass).

Test Plan:
- Identity S (s[x]=x), MESSAGE_LEN=2, CHECK_EN=0, ciphertext {8'h63, 8'h64} -> keystream {2, 5}; result {8'h61, 8'h61}; pass=1; bytes_done=2; finish at cycle 19; afterwards s[2]=3, s[3]=2.
- Identity S, CHECK_EN=1, ciphertext byte1 = 8'h05 (plaintext 0x00) -> exactly 2 result_wren pulses; finish with pass=0; bytes_done=2; no further S writes.
- MESSAGE_LEN=1, ALLOW_SPACE=1, plaintext 0x20 -> pass=1, finish at cycle 10; plaintext 0x7B -> pass=0.
- rst_n pulsed low during WR_J of byte 3 -> all outputs 0 asynchronously; block idle. A new start then runs cleanly from i=1, j=0 on a reloaded identity S and reproduces scenario 1's results.
- start held high through DONE for 20 cycles -> finish stays 1 with no restart. Drop start for 1 cycle, then re-raise -> second run begins; finish falls, then rises again.
- MESSAGE_LEN=256, MSG_ADDR_WIDTH=8, CHECK_EN=0, against a software RC4 model -> all 256 result bytes match; i wraps to 0 at byte 256; finish at cycle 2305.

Source files
------------

// File: rtl/rc4_prga_checker_if.sv
// Control handshake plus scratch, message and result memory ports of the RC4 PRGA block.
interface rc4_prga_checker_if #(
    parameter int unsigned MSG_ADDR_WIDTH = 5
);
    logic                      start;
    logic                      finish;
    logic                      pass;
    logic [MSG_ADDR_WIDTH:0]   bytes_done;
    logic [7:0]                s_addr;
    logic [7:0]                s_data;
    logic                      s_wren;
    logic [7:0]                s_q;
    logic [MSG_ADDR_WIDTH-1:0] msg_addr;
    logic [7:0]                msg_q;
    logic [MSG_ADDR_WIDTH-1:0] result_addr;
    logic [7:0]                result_data;
    logic                      result_wren;

    // Controller and memories side
    modport master (
        output start, s_q, msg_q,
        input  finish, pass, bytes_done, s_addr, s_data, s_wren,
               msg_addr, result_addr, result_data, result_wren
    );

    // PRGA engine side
    modport slave (
        input  start, s_q, msg_q,
        output finish, pass, bytes_done, s_addr, s_data, s_wren,
               msg_addr, result_addr, result_data, result_wren
    );
endinterface

// File: rtl/rc4_prga_checker.sv
// RC4 keystream generator / decrypter with optional early abort on an illegal plaintext byte.
module rc4_prga_checker #(
    parameter int unsigned MESSAGE_LEN    = 32,
    parameter int unsigned MSG_ADDR_WIDTH = 5,
    parameter bit          CHECK_EN       = 1'b1,
    parameter logic [7:0]  CHAR_LO        = 8'd97,
    parameter logic [7:0]  CHAR_HI        = 8'd122,
    parameter bit          ALLOW_SPACE    = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    rc4_prga_checker_if.slave bus
);
    localparam int unsigned AW = MSG_ADDR_WIDTH;
    localparam int unsigned CW = MSG_ADDR_WIDTH + 1;
    localparam logic [AW-1:0] K_LAST = AW'(MESSAGE_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J, RD_F, LD_F, WR_R, DONE
    } state_t;

    state_t        state;
    logic [7:0]    i;
    logic [7:0]    j;
    logic [7:0]    si;
    logic [7:0]    sj;
    logic [7:0]    f;
    logic [7:0]    m;
    logic [AW-1:0] k;

    logic [7:0]    plain_c;
    logic          legal_c;

    // Plaintext byte of the current step and its legality
    assign plain_c = f ^ m;
    assign legal_c = ((plain_c >= CHAR_LO) && (plain_c <= CHAR_HI)) ||
                     (ALLOW_SPACE && (plain_c == 8'd32));

    // Sequencer; memory-facing outputs are loaded on entry to the state that uses them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            i               <= 8'd0;
            j               <= 8'd0;
            k               <= '0;
            si              <= 8'd0;
            sj              <= 8'd0;
            f               <= 8'd0;
            m               <= 8'd0;
            bus.finish      <= 1'b0;
            bus.pass        <= 1'b0;
            bus.bytes_done  <= '0;
            bus.s_addr      <= 8'd0;
            bus.s_data      <= 8'd0;
            bus.s_wren      <= 1'b0;
            bus.msg_addr    <= '0;
            bus.result_addr <= '0;
            bus.result_data <= 8'd0;
            bus.result_wren <= 1'b0;
        end else begin
            bus.s_wren      <= 1'b0;
            bus.result_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state          <= RD_I;
                        i              <= 8'd1;
                        j              <= 8'd0;
                        k              <= '0;
                        bus.bytes_done <= '0;
                        bus.pass       <= 1'b0;
                        bus.s_addr     <= 8'd1;
                    end
                end
                RD_I: state <= LD_I;
                LD_I: begin
                    si         <= bus.s_q;
                    j          <= j + bus.s_q;
                    bus.s_addr <= j + bus.s_q;
                    state      <= RD_J;
                end
                RD_J: state <= LD_J;
                LD_J: begin
                    sj         <= bus.s_q;
                    bus.s_addr <= i;
                    bus.s_data <= bus.s_q;
                    bus.s_wren <= 1'b1;
                    state      <= WR_I;
                end
                WR_I: begin
                    bus.s_addr <= j;
                    bus.s_data <= si;
                    bus.s_wren <= 1'b1;
                    state      <= WR_J;
                end
                WR_J: begin
                    bus.s_addr   <= si + sj;
                    bus.msg_addr <= k;
                    state        <= RD_F;
                end
                RD_F: state <= LD_F;
                LD_F: begin
                    f               <= bus.s_q;
                    m               <= bus.msg_q;
                    bus.result_addr <= k;
                    bus.result_data <= bus.s_q ^ bus.msg_q;
                    bus.result_wren <= 1'b1;
                    state           <= WR_R;
                end
                WR_R: begin
                    bus.bytes_done <= CW'(k) + CW'(1);
                    if (CHECK_EN && !legal_c) begin
                        bus.pass   <= 1'b0;
                        bus.finish <= 1'b1;
                        state      <= DONE;
                    end else if (k == K_LAST) begin
                        bus.pass   <= 1'b1;
                        bus.finish <= 1'b1;
                        state      <= DONE;
                    end else begin
                        k          <= k + AW'(1);
                        i          <= i + 8'd1;
                        bus.s_addr <= i + 8'd1;
                        state      <= RD_I;
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        bus.finish <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rc4_prga_checker.sv
// Directed bench for rc4_prga_checker: four configurations with behavioural memories.
module tb_rc4_prga_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    rc4_prga_checker_if #(.MSG_ADDR_WIDTH(5)) bus_a ();
    rc4_prga_checker_if #(.MSG_ADDR_WIDTH(5)) bus_b ();
    rc4_prga_checker_if #(.MSG_ADDR_WIDTH(5)) bus_c ();
    rc4_prga_checker_if #(.MSG_ADDR_WIDTH(8)) bus_d ();

    rc4_prga_checker #(.MESSAGE_LEN(2), .MSG_ADDR_WIDTH(5), .CHECK_EN(1'b0),
        .CHAR_LO(8'd97), .CHAR_HI(8'd122), .ALLOW_SPACE(1'b1))
        u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    rc4_prga_checker #(.MESSAGE_LEN(4), .MSG_ADDR_WIDTH(5), .CHECK_EN(1'b1),
        .CHAR_LO(8'd97), .CHAR_HI(8'd122), .ALLOW_SPACE(1'b1))
        u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    rc4_prga_checker #(.MESSAGE_LEN(1), .MSG_ADDR_WIDTH(5), .CHECK_EN(1'b1),
        .CHAR_LO(8'd97), .CHAR_HI(8'd122), .ALLOW_SPACE(1'b1))
        u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));
    rc4_prga_checker #(.MESSAGE_LEN(256), .MSG_ADDR_WIDTH(8), .CHECK_EN(1'b0),
        .CHAR_LO(8'd97), .CHAR_HI(8'd122), .ALLOW_SPACE(1'b1))
        u_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));

    logic [7:0] init_s [256];
    logic [3:0] load_req = 4'd0;
    logic [7:0] exp_res [256];

    logic [7:0] s_a [256];
    logic [7:0] s_b [256];
    logic [7:0] s_c [256];
    logic [7:0] s_d [256];
    logic [7:0] rom_a [32];
    logic [7:0] rom_b [32];
    logic [7:0] rom_c [32];
    logic [7:0] rom_d [256];
    logic [7:0] res_a [32];
    logic [7:0] res_b [32];
    logic [7:0] res_c [32];
    logic [7:0] res_d [256];
    int s_wr_a = 0, s_wr_b = 0, s_wr_c = 0, s_wr_d = 0;
    int r_wr_a = 0, r_wr_b = 0, r_wr_c = 0, r_wr_d = 0;

    // Synchronous memories for instance a
    always @(posedge clk) begin
        if (load_req[0]) begin
            for (int x = 0; x < 256; x++) s_a[x] <= init_s[x];
        end else if (bus_a.s_wren) begin
            s_a[bus_a.s_addr] <= bus_a.s_data;
            s_wr_a <= s_wr_a + 1;
        end
        if (bus_a.result_wren) begin
            res_a[bus_a.result_addr] <= bus_a.result_data;
            r_wr_a <= r_wr_a + 1;
        end
        bus_a.s_q   <= s_a[bus_a.s_addr];
        bus_a.msg_q <= rom_a[bus_a.msg_addr];
    end

    // Synchronous memories for instance b
    always @(posedge clk) begin
        if (load_req[1]) begin
            for (int x = 0; x < 256; x++) s_b[x] <= init_s[x];
        end else if (bus_b.s_wren) begin
            s_b[bus_b.s_addr] <= bus_b.s_data;
            s_wr_b <= s_wr_b + 1;
        end
        if (bus_b.result_wren) begin
            res_b[bus_b.result_addr] <= bus_b.result_data;
            r_wr_b <= r_wr_b + 1;
        end
        bus_b.s_q   <= s_b[bus_b.s_addr];
        bus_b.msg_q <= rom_b[bus_b.msg_addr];
    end

    // Synchronous memories for instance c
    always @(posedge clk) begin
        if (load_req[2]) begin
            for (int x = 0; x < 256; x++) s_c[x] <= init_s[x];
        end else if (bus_c.s_wren) begin
            s_c[bus_c.s_addr] <= bus_c.s_data;
            s_wr_c <= s_wr_c + 1;
        end
        if (bus_c.result_wren) begin
            res_c[bus_c.result_addr] <= bus_c.result_data;
            r_wr_c <= r_wr_c + 1;
        end
        bus_c.s_q   <= s_c[bus_c.s_addr];
        bus_c.msg_q <= rom_c[bus_c.msg_addr];
    end

    // Synchronous memories for instance d
    always @(posedge clk) begin
        if (load_req[3]) begin
            for (int x = 0; x < 256; x++) s_d[x] <= init_s[x];
        end else if (bus_d.s_wren) begin
            s_d[bus_d.s_addr] <= bus_d.s_data;
            s_wr_d <= s_wr_d + 1;
        end
        if (bus_d.result_wren) begin
            res_d[bus_d.result_addr] <= bus_d.result_data;
            r_wr_d <= r_wr_d + 1;
        end
        bus_d.s_q   <= s_d[bus_d.s_addr];
        bus_d.msg_q <= rom_d[bus_d.msg_addr];
    end

    task automatic set_start(input int which, input logic v);
        case (which)
            0: bus_a.start = v;
            1: bus_b.start = v;
            2: bus_c.start = v;
            default: bus_d.start = v;
        endcase
    endtask

    task automatic identity_s();
        for (int x = 0; x < 256; x++) init_s[x] = 8'(x);
    endtask

    // Copy init_s into one instance's scratch RAM in a single cycle
    task automatic load_s(input int which);
        @(posedge clk); #1;
        load_req[which] = 1'b1;
        @(posedge clk); #1;
        load_req = 4'd0;
    endtask

    // Raise start just after an edge; the following edge is cycle-count edge 0
    task automatic go(input int which);
        @(posedge clk); #1;
        set_start(which, 1'b1);
    endtask

    // Returns the cycle number at which finish is first seen high, or -1 on timeout
    task automatic wait_finish(input int which, input int limit, output int cyc);
        logic fin;
        cyc = -1;
        @(posedge clk);
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk); #1;
            case (which)
                0: fin = bus_a.finish;
                1: fin = bus_b.finish;
                2: fin = bus_c.finish;
                default: fin = bus_d.finish;
            endcase
            if (fin) begin
                cyc = c + 1;
                break;
            end
        end
    endtask

    task automatic stop(input int which);
        set_start(which, 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Reference RC4 PRGA over init_s and rom_d
    task automatic rc4_model(input int n);
        logic [7:0] s [256];
        logic [7:0] i, j, t;
        for (int x = 0; x < 256; x++) s[x] = init_s[x];
        i = 8'd0;
        j = 8'd0;
        for (int kk = 0; kk < n; kk++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            exp_res[kk] = rom_d[kk] ^ s[t];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_a.finish, bus_a.pass, bus_a.bytes_done, bus_a.s_addr, bus_a.s_data, bus_a.s_wren,
             bus_a.msg_addr, bus_a.result_addr, bus_a.result_data, bus_a.result_wren} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_a: finish=%b pass=%b bytes_done=%0d s_wren=%b result_wren=%b, expected all zero",
                     bus_a.finish, bus_a.pass, bus_a.bytes_done, bus_a.s_wren, bus_a.result_wren);
        end
        n_checks++;
        if ({bus_d.finish, bus_d.pass, bus_d.bytes_done, bus_d.s_addr, bus_d.s_data, bus_d.s_wren,
             bus_d.msg_addr, bus_d.result_addr, bus_d.result_data, bus_d.result_wren} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_d: finish=%b pass=%b bytes_done=%0d s_wren=%b, expected all zero",
                     bus_d.finish, bus_d.pass, bus_d.bytes_done, bus_d.s_wren);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc, rw0;
        identity_s();
        load_s(0);
        rom_a[0] = 8'h63;
        rom_a[1] = 8'h64;
        rw0 = r_wr_a;
        go(0);
        wait_finish(0, 100, cyc);
        n_checks++;
        if (cyc !== 19) begin n_fail++; $display("FAIL basic_latency: got %0d expected 19", cyc); end
        n_checks++;
        if (bus_a.pass !== 1'b1) begin n_fail++; $display("FAIL basic_pass: got %b expected 1", bus_a.pass); end
        n_checks++;
        if (bus_a.bytes_done !== 6'd2) begin n_fail++; $display("FAIL basic_bytes_done: got %0d expected 2", bus_a.bytes_done); end
        n_checks++;
        if (res_a[0] !== 8'h61 || res_a[1] !== 8'h61) begin
            n_fail++; $display("FAIL basic_result: got %h %h expected 61 61", res_a[0], res_a[1]);
        end
        n_checks++;
        if (s_a[2] !== 8'd3 || s_a[3] !== 8'd2) begin
            n_fail++; $display("FAIL basic_swap: s[2]=%0d s[3]=%0d expected 3 2", s_a[2], s_a[3]);
        end
        n_checks++;
        if (r_wr_a - rw0 !== 2) begin n_fail++; $display("FAIL basic_result_writes: got %0d expected 2", r_wr_a - rw0); end
        stop(0);
    endtask

    task automatic test_abort();
        int cyc, sw0, rw0;
        identity_s();
        load_s(1);
        rom_b[0] = 8'h63;
        rom_b[1] = 8'h05;
        rom_b[2] = 8'h63;
        rom_b[3] = 8'h63;
        sw0 = s_wr_b;
        rw0 = r_wr_b;
        go(1);
        wait_finish(1, 100, cyc);
        n_checks++;
        if (cyc !== 19) begin n_fail++; $display("FAIL abort_latency: got %0d expected 19", cyc); end
        n_checks++;
        if (bus_b.pass !== 1'b0) begin n_fail++; $display("FAIL abort_pass: got %b expected 0", bus_b.pass); end
        n_checks++;
        if (bus_b.bytes_done !== 6'd2) begin n_fail++; $display("FAIL abort_bytes_done: got %0d expected 2", bus_b.bytes_done); end
        n_checks++;
        if (res_b[1] !== 8'h00) begin n_fail++; $display("FAIL abort_illegal_written: got %h expected 00", res_b[1]); end
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (r_wr_b - rw0 !== 2) begin n_fail++; $display("FAIL abort_result_writes: got %0d expected 2", r_wr_b - rw0); end
        n_checks++;
        if (s_wr_b - sw0 !== 4) begin n_fail++; $display("FAIL abort_s_writes: got %0d expected 4", s_wr_b - sw0); end
        n_checks++;
        if (bus_b.finish !== 1'b1) begin n_fail++; $display("FAIL abort_finish_held: got %b expected 1", bus_b.finish); end
        stop(1);
    endtask

    task automatic test_space();
        int cyc;
        identity_s();
        load_s(2);
        rom_c[0] = 8'h22;
        go(2);
        wait_finish(2, 50, cyc);
        n_checks++;
        if (cyc !== 10) begin n_fail++; $display("FAIL space_latency: got %0d expected 10", cyc); end
        n_checks++;
        if (bus_c.pass !== 1'b1) begin n_fail++; $display("FAIL space_pass: got %b expected 1", bus_c.pass); end
        n_checks++;
        if (res_c[0] !== 8'h20) begin n_fail++; $display("FAIL space_result: got %h expected 20", res_c[0]); end
        stop(2);
        load_s(2);
        rom_c[0] = 8'h79;
        go(2);
        wait_finish(2, 50, cyc);
        n_checks++;
        if (cyc !== 10) begin n_fail++; $display("FAIL brace_latency: got %0d expected 10", cyc); end
        n_checks++;
        if (bus_c.pass !== 1'b0) begin n_fail++; $display("FAIL brace_pass: got %b expected 0", bus_c.pass); end
        n_checks++;
        if (bus_c.bytes_done !== 6'd1 || res_c[0] !== 8'h7b) begin
            n_fail++; $display("FAIL brace_written: bytes_done=%0d result=%h expected 1 7b", bus_c.bytes_done, res_c[0]);
        end
        stop(2);
    endtask

    task automatic test_mid_reset();
        int cyc, sw0, rw0, errs;
        identity_s();
        load_s(3);
        for (int x = 0; x < 256; x++) rom_d[x] = 8'h00;
        rom_d[0] = 8'h63;
        rom_d[1] = 8'h64;
        go(3);
        @(posedge clk);
        repeat (23) @(posedge clk);
        #1;
        n_checks++;
        if (bus_d.s_wren !== 1'b1 || bus_d.s_addr !== 8'd5 || bus_d.s_data !== 8'd2) begin
            n_fail++;
            $display("FAIL midrst_wr_j: s_wren=%b s_addr=%0d s_data=%0d expected 1 5 2",
                     bus_d.s_wren, bus_d.s_addr, bus_d.s_data);
        end
        #1 rst_n = 1'b0;
        bus_d.start = 1'b0;
        #1;
        n_checks++;
        if ({bus_d.finish, bus_d.pass, bus_d.bytes_done, bus_d.s_addr, bus_d.s_data, bus_d.s_wren,
             bus_d.msg_addr, bus_d.result_addr, bus_d.result_data, bus_d.result_wren} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: s_wren=%b s_addr=%0d bytes_done=%0d, expected all zero",
                     bus_d.s_wren, bus_d.s_addr, bus_d.bytes_done);
        end
        sw0 = s_wr_d;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (s_wr_d !== sw0 || bus_d.finish !== 1'b0 || bus_d.s_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: extra_writes=%0d finish=%b expected 0 0", s_wr_d - sw0, bus_d.finish);
        end
        identity_s();
        load_s(3);
        rc4_model(256);
        sw0 = s_wr_d;
        rw0 = r_wr_d;
        go(3);
        wait_finish(3, 2400, cyc);
        n_checks++;
        if (cyc !== 2305 || bus_d.pass !== 1'b1) begin
            n_fail++; $display("FAIL midrst_rerun_finish: cycle=%0d pass=%b expected 2305 1", cyc, bus_d.pass);
        end
        n_checks++;
        if (res_d[0] !== 8'h61 || res_d[1] !== 8'h61) begin
            n_fail++; $display("FAIL midrst_rerun_first: got %h %h expected 61 61", res_d[0], res_d[1]);
        end
        errs = 0;
        for (int x = 0; x < 256; x++) if (res_d[x] !== exp_res[x]) errs++;
        n_checks++;
        if (errs !== 0 || r_wr_d - rw0 !== 256 || s_wr_d - sw0 !== 512) begin
            n_fail++;
            $display("FAIL midrst_rerun_all: bad_bytes=%0d result_writes=%0d s_writes=%0d expected 0 256 512",
                     errs, r_wr_d - rw0, s_wr_d - sw0);
        end
        stop(3);
    endtask

    task automatic test_hold_start();
        int cyc, rw0;
        logic held;
        identity_s();
        load_s(0);
        rom_a[0] = 8'h63;
        rom_a[1] = 8'h64;
        rw0 = r_wr_a;
        go(0);
        wait_finish(0, 100, cyc);
        held = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus_a.finish !== 1'b1) held = 1'b0;
        end
        n_checks++;
        if (held !== 1'b1 || r_wr_a - rw0 !== 2) begin
            n_fail++; $display("FAIL hold_no_restart: finish_held=%b result_writes=%0d expected 1 2", held, r_wr_a - rw0);
        end
        bus_a.start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus_a.finish !== 1'b0) begin n_fail++; $display("FAIL hold_finish_fall: got %b expected 0", bus_a.finish); end
        identity_s();
        load_s(0);
        go(0);
        wait_finish(0, 100, cyc);
        n_checks++;
        if (cyc !== 19 || bus_a.pass !== 1'b1 || res_a[1] !== 8'h61) begin
            n_fail++;
            $display("FAIL hold_second_run: cycle=%0d pass=%b result1=%h expected 19 1 61", cyc, bus_a.pass, res_a[1]);
        end
        stop(0);
    endtask

    task automatic test_long();
        int cyc, rw0;
        logic [7:0] key [5];
        logic [7:0] j, t;
        key = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
        identity_s();
        j = 8'd0;
        for (int x = 0; x < 256; x++) begin
            j = j + init_s[x] + key[x % 5];
            t = init_s[x]; init_s[x] = init_s[j]; init_s[j] = t;
        end
        for (int x = 0; x < 256; x++) rom_d[x] = 8'($urandom);
        rc4_model(256);
        load_s(3);
        rw0 = r_wr_d;
        go(3);
        cyc = -1;
        @(posedge clk);
        for (int c = 1; c <= 2400; c++) begin
            @(posedge clk); #1;
            if (c == 2286) begin
                n_checks++;
                if (bus_d.s_addr !== 8'd255) begin n_fail++; $display("FAIL long_i_255: got %0d expected 255", bus_d.s_addr); end
            end
            if (c == 2295) begin
                n_checks++;
                if (bus_d.s_addr !== 8'd0) begin n_fail++; $display("FAIL long_i_wrap: got %0d expected 0", bus_d.s_addr); end
            end
            if (bus_d.finish) begin
                cyc = c + 1;
                break;
            end
        end
        n_checks++;
        if (cyc !== 2305) begin n_fail++; $display("FAIL long_latency: got %0d expected 2305", cyc); end
        n_checks++;
        if (bus_d.pass !== 1'b1 || bus_d.bytes_done !== 9'd256) begin
            n_fail++; $display("FAIL long_status: pass=%b bytes_done=%0d expected 1 256", bus_d.pass, bus_d.bytes_done);
        end
        n_checks++;
        if (r_wr_d - rw0 !== 256) begin n_fail++; $display("FAIL long_result_writes: got %0d expected 256", r_wr_d - rw0); end
        for (int x = 0; x < 256; x++) begin
            n_checks++;
            if (res_d[x] !== exp_res[x]) begin
                n_fail++; $display("FAIL long_byte[%0d]: got %h expected %h", x, res_d[x], exp_res[x]);
            end
        end
        stop(3);
    endtask

    // Scenario sequence
    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_c.start = 1'b0;
        bus_d.start = 1'b0;
        for (int x = 0; x < 32; x++) begin
            rom_a[x] = 8'h00;
            rom_b[x] = 8'h00;
            rom_c[x] = 8'h00;
        end
        test_reset();
        test_basic();
        test_abort();
        test_space();
        test_mid_reset();
        test_hold_start();
        test_long();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
